// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle CPU control unit: IF/ID/EXE/MEM/WB sequencer plus datapath controls.
// Adds a data-memory wait, a sticky halt, an illegal-opcode pulse and a retire counter.
module multicycle_ctrl_fsm #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32,
  parameter logic [OPCODE_W-1:0] HALT_OP = OPCODE_W'(6'h3F)
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                zero,
  input  logic                sign,
  input  logic                mem_ready,
  output logic [2:0]          State,
  output logic                PCWre,
  output logic                IRWre,
  output logic                RegWre,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                DBDataSrc,
  output logic                RegDst,
  output logic                ExtSel,
  output logic                InsMemRW,
  output logic                nRD,
  output logic                nWR,
  output logic [1:0]          PCSrc,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'b010000);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'b010001);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b010010);
  localparam logic [OPCODE_W-1:0] OP_SLL  = OPCODE_W'(6'b011000);
  localparam logic [OPCODE_W-1:0] OP_SLT  = OPCODE_W'(6'b100110);
  localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(6'b100111);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b110000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b110001);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b110100);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b110101);
  localparam logic [OPCODE_W-1:0] OP_BGTZ = OPCODE_W'(6'b110110);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b111000);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b110);

  state_t           r_state;
  state_t           w_next;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  logic w_add, w_sub, w_addi, w_or, w_and, w_ori;
  logic w_sll, w_slt, w_slti, w_sw, w_lw;
  logic w_beq, w_bne, w_bgtz, w_j, w_halt;
  logic w_rtype, w_alu, w_ls, w_br, w_bad, w_legal;
  logic w_taken, w_immb;

  assign w_add  = (Opcode == OP_ADD);
  assign w_sub  = (Opcode == OP_SUB);
  assign w_addi = (Opcode == OP_ADDI);
  assign w_or   = (Opcode == OP_OR);
  assign w_and  = (Opcode == OP_AND);
  assign w_ori  = (Opcode == OP_ORI);
  assign w_sll  = (Opcode == OP_SLL);
  assign w_slt  = (Opcode == OP_SLT);
  assign w_slti = (Opcode == OP_SLTI);
  assign w_sw   = (Opcode == OP_SW);
  assign w_lw   = (Opcode == OP_LW);
  assign w_beq  = (Opcode == OP_BEQ);
  assign w_bne  = (Opcode == OP_BNE);
  assign w_bgtz = (Opcode == OP_BGTZ);
  assign w_j    = (Opcode == OP_J);
  assign w_halt = (Opcode == HALT_OP);

  assign w_rtype = w_add | w_sub | w_or | w_and | w_sll | w_slt;
  assign w_alu   = w_rtype | w_addi | w_ori | w_slti;
  assign w_ls    = w_sw | w_lw;
  assign w_br    = w_beq | w_bne | w_bgtz;
  assign w_bad   = ~(w_alu | w_ls | w_br | w_j | w_halt);
  assign w_legal = ~w_bad & ~w_halt;
  assign w_immb  = w_addi | w_ori | w_slti | w_ls;

  assign w_taken = (w_beq & zero) | (w_bne & ~zero)
                 | (w_bgtz & ~zero & ~sign);

  always_comb begin
    w_next = r_state;
    if (!r_halted) begin
      unique case (r_state)
        S_IF: w_next = S_ID;
        S_ID: begin
          unique case (1'b1)
            w_alu:   w_next = S_EXE_AL;
            w_ls:    w_next = S_EXE_LS;
            w_br:    w_next = S_EXE_BR;
            w_halt:  w_next = S_ID;
            default: w_next = S_IF;
          endcase
        end
        S_EXE_LS: w_next = S_MEM;
        S_MEM: begin
          if (mem_ready)
            w_next = w_lw ? S_WB_LD : S_IF;
        end
        S_WB_LD:  w_next = S_IF;
        S_EXE_BR: w_next = S_IF;
        S_EXE_AL: w_next = S_WB_AL;
        S_WB_AL:  w_next = S_IF;
        default:  w_next = S_IF;
      endcase
    end
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    RegDst    = 1'b0;
    ExtSel    = 1'b0;
    nRD       = 1'b1;
    nWR       = 1'b1;
    PCSrc     = 2'b00;
    ALUOp     = ALU_ADD;
    illegal   = 1'b0;
    if (!r_halted) begin
      IRWre = (r_state == S_IF);
      // datapath muxes track the opcode from decode until the last cycle
      if (r_state != S_IF) begin
        ALUSrcA   = w_sll;
        ALUSrcB   = w_immb;
        RegDst    = w_rtype;
        DBDataSrc = w_lw;
        ExtSel    = w_legal & ~w_ori;
        unique case (1'b1)
          w_sub | w_br:   ALUOp = ALU_SUB;
          w_sll:          ALUOp = ALU_SLL;
          w_or | w_ori:   ALUOp = ALU_OR;
          w_and:          ALUOp = ALU_AND;
          w_slt | w_slti: ALUOp = ALU_SLT;
          default:        ALUOp = ALU_ADD;
        endcase
      end
      unique case (r_state)
        S_ID: begin
          illegal = w_bad;
          if (w_j) begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
          end else if (w_bad) begin
            PCWre = 1'b1;
          end
        end
        S_MEM: begin
          nRD   = ~w_lw;
          nWR   = ~w_sw;
          PCWre = w_sw & mem_ready;
        end
        S_WB_LD, S_WB_AL: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = w_taken ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IF;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID && w_halt)
        r_halted <= 1'b1;
      if (PCWre && !w_bad)
        r_retired <= r_retired + 1'b1;
    end
  end

  assign State    = r_state;
  assign InsMemRW = 1'b1;
  assign halted   = r_halted;
  assign retired  = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction state tables from the
// instruction's class, randomized opcodes, wait states and flags.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [5:0]  Opcode;
  logic        zero, sign, mem_ready;
  logic [2:0]  State;
  logic        PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB;
  logic        DBDataSrc, RegDst, ExtSel, InsMemRW, nRD, nWR;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUOp;
  logic        halted, illegal;
  logic [31:0] retired;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned exp_ret = 0;

  logic [5:0] legal_ops [15] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
    6'b010010, 6'b011000, 6'b100110, 6'b100111, 6'b110000,
    6'b110001, 6'b110100, 6'b110101, 6'b110110, 6'b111000};

  multicycle_ctrl_fsm dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode),
    .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .State(State), .PCWre(PCWre), .IRWre(IRWre),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .DBDataSrc(DBDataSrc), .RegDst(RegDst), .ExtSel(ExtSel),
    .InsMemRW(InsMemRW), .nRD(nRD), .nWR(nWR),
    .PCSrc(PCSrc), .ALUOp(ALUOp), .halted(halted),
    .illegal(illegal), .retired(retired));

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // 0 alu, 1 lw, 2 sw, 3 branch, 4 j, 5 illegal, 6 halt
  function automatic int op_class(logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
      6'b010010, 6'b011000, 6'b100110, 6'b100111: return 0;
      6'b110001: return 1;
      6'b110000: return 2;
      6'b110100, 6'b110101, 6'b110110: return 3;
      6'b111000: return 4;
      6'b111111: return 6;
      default: return 5;
    endcase
  endfunction

  function automatic logic [2:0] exp_aluop(logic [5:0] op);
    case (op)
      6'b000001, 6'b110100, 6'b110101, 6'b110110: return 3'b001;
      6'b011000: return 3'b010;
      6'b010000, 6'b010010: return 3'b011;
      6'b010001: return 3'b100;
      6'b100110, 6'b100111: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // {ALUSrcA, ALUSrcB, RegDst, DBDataSrc, ExtSel}
  function automatic logic [4:0] exp_mux(logic [5:0] op);
    logic a, b, rd;
    a  = (op == 6'b011000);
    b  = op inside {6'b000010, 6'b010010, 6'b100111,
                    6'b110000, 6'b110001};
    rd = op inside {6'b000000, 6'b000001, 6'b010000,
                    6'b010001, 6'b011000, 6'b100110};
    return {a, b, rd, op == 6'b110001, op != 6'b010010};
  endfunction

  task automatic run_instr(input logic [5:0] op, input int waits,
                           input logic z, input logic s);
    int c;
    int seq[$];
    int st, m;
    logic last, taken;
    logic [1:0] psrc;
    c = op_class(op);
    case (c)
      0: seq = '{0, 1, 6, 7};
      1: begin
        seq = '{0, 1, 2};
        repeat (waits + 1) seq.push_back(3);
        seq.push_back(4);
      end
      2: begin
        seq = '{0, 1, 2};
        repeat (waits + 1) seq.push_back(3);
      end
      3: seq = '{0, 1, 5};
      default: seq = '{0, 1};
    endcase
    taken = (op == 6'b110100 && z) || (op == 6'b110101 && !z)
         || (op == 6'b110110 && !z && !s);
    m = 0;
    for (int k = 0; k < seq.size(); k++) begin
      st = seq[k];
      last = (k == seq.size() - 1);
      @(negedge CLK);
      Opcode = op;
      zero = z;
      sign = s;
      if (st == 3) begin
        mem_ready = (m == waits);
        m++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      check("state", State, st);
      check("irwre", IRWre, st == 0);
      check("pcwre", PCWre, last);
      check("regwre", RegWre, st == 4 || st == 7);
      check("nrd", nRD, !(st == 3 && c == 1));
      check("nwr", nWR, !(st == 3 && c == 2));
      check("illegal", illegal, c == 5 && st == 1);
      check("retired", retired, exp_ret);
      psrc = 2'b00;
      if (last && c == 3) psrc = taken ? 2'b01 : 2'b00;
      if (last && c == 4) psrc = 2'b10;
      check("pcsrc", PCSrc, psrc);
      if (st != 0 && c < 5) begin
        check("aluop", ALUOp, exp_aluop(op));
        check("mux", {ALUSrcA, ALUSrcB, RegDst, DBDataSrc, ExtSel},
              exp_mux(op));
      end
    end
    if (c != 5) exp_ret++;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #2 Reset = 1'b1;
    exp_ret = 0;
  endtask

  initial begin
    logic [5:0] op;
    Reset = 1'b0;
    Opcode = 6'b0;
    zero = 1'b0;
    sign = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_state", State, 3'b000);
    check("rst_irwre", IRWre, 1'b1);
    check("rst_nrd_nwr", {nRD, nWR}, 2'b11);
    check("rst_pcwre", PCWre, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_retired", retired, 0);
    check("insmemrw", InsMemRW, 1'b1);
    @(posedge CLK);
    #2 Reset = 1'b1;

    run_instr(6'b000000, 0, 1'b0, 1'b0);
    run_instr(6'b110001, 2, 1'b0, 1'b0);
    run_instr(6'b110000, 0, 1'b0, 1'b0);
    run_instr(6'b110100, 0, 1'b1, 1'b0);
    run_instr(6'b110100, 0, 1'b0, 1'b0);
    run_instr(6'b110110, 0, 1'b0, 1'b1);
    run_instr(6'b110101, 0, 1'b0, 1'b0);
    run_instr(6'b101010, 0, 1'b0, 1'b0);
    run_instr(6'b111000, 0, 1'b0, 1'b0);
    run_instr(6'b011000, 0, 1'b0, 1'b0);
    run_instr(6'b010010, 0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        op = 6'($urandom_range(0, 62));
      end else begin
        op = legal_ops[$urandom_range(0, 14)];
      end
      run_instr(op, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset asserted while a load is waiting in MEM
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      Opcode = 6'b110001;
      mem_ready = 1'b0;
    end
    #1;
    check("mid_state", State, 3'b011);
    check("mid_nrd", nRD, 1'b0);
    #2 Reset = 1'b0;
    #1;
    check("arst_state", State, 3'b000);
    check("arst_nrd", nRD, 1'b1);
    check("arst_retired", retired, 0);
    check("arst_halted", halted, 1'b0);
    check("arst_irwre", IRWre, 1'b1);
    @(negedge CLK);
    #1;
    check("arst2_state", State, 3'b000);
    check("arst2_nrd", nRD, 1'b1);
    @(posedge CLK);
    #2 Reset = 1'b1;
    exp_ret = 0;

    for (int i = 0; i < 3; i++) begin
      run_instr(legal_ops[$urandom_range(0, 14)], 1,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge CLK);
    Opcode = 6'h3F;
    mem_ready = 1'b1;
    #1;
    check("halt_if", State, 3'b000);
    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      #1;
      check("halt_state", State, 3'b001);
      check("halt_pcwre", PCWre, 1'b0);
      check("halt_regwre", RegWre, 1'b0);
      check("halt_retired", retired, 3);
      check("halt_illegal", illegal, 1'b0);
      if (i > 0) check("halted", halted, 1'b1);
    end
    do_reset();
    @(negedge CLK);
    #1;
    check("post_halt_halted", halted, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
